ercm_pipe: RTL

Parametrised, pipelined successor to the 8-bit error-recovery approximate multiplier. It computes an unsigned WIDTH×WIDTH product whose final carry-propagate adder can suppress carry-generate per column under a run-time mask. The block adds a 3-stage valid/ready pipeline, an exact-vs-approximate error flag and a saturating error-event counter for on-line accuracy monitoring. It sits between the operand source and the accumulate/consume logic of the datapath.

---
 rtl/ercm_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ercm_pipe.sv
// ercm_pipe: 3-stage valid/ready pipelined error-recovery approximate multiplier.
// Computes an unsigned WIDTH x WIDTH product. The final carry-propagate adder
// can drop carry-generate per column under a run-time mask. It also flags
// results that differ from the exact product and counts delivered errors.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   dat_in_a, dat_in_b    unsigned operands
//   mask                  bit k: 1 = column MASK_LSB+k exact, 0 = approximate
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   dat_o, err_o          approximate product, differs-from-exact flag
//   out_valid / out_ready result handshake
//   cnt_clr               synchronous clear of err_cnt
//   err_cnt               saturating count of delivered results with err_o=1
module ercm_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MASK_LSB = WIDTH / 2 + 1,
  parameter int unsigned MASK_W   = WIDTH - 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     dat_in_a,
  input  logic [WIDTH-1:0]     dat_in_b,
  input  logic [MASK_W-1:0]    mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   dat_o,
  output logic                 err_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;

  // Stage 1: operands and mask
  logic              v1;
  logic [WIDTH-1:0]  a1, b1;
  logic [MASK_W-1:0] m1;

  // Stage 2: partial-product rows and mask
  logic              v2;
  logic [PW-1:0]     x2, y2;
  logic [MASK_W-1:0] m2;

  logic              en;
  logic [PW-1:0]     x_c, y_c;
  logic [PW-1:0]     col_exact;
  logic [PW-1:0]     approx_c;
  logic [PW-1:0]     exact_c;
  logic              carry;
  logic              err_c;

  // Whole pipeline advances together whenever the output slot is free or drains
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Split multiplication: low half of A times B, high half of A times B shifted
  assign x_c = PW'(a1[H-1:0]) * PW'(b1);
  assign y_c = (PW'(a1[WIDTH-1:H]) * PW'(b1)) << H;

  // Final adder: masked columns keep propagate but never generate a carry
  always_comb begin
    col_exact = '1;
    for (int k = 0; k < int'(MASK_W); k++) begin
      col_exact[int'(MASK_LSB) + k] = m2[k];
    end
    carry    = 1'b0;
    approx_c = '0;
    for (int i = 0; i < int'(PW); i++) begin
      if (col_exact[i]) begin
        approx_c[i] = x2[i] ^ y2[i] ^ carry;
        carry       = (x2[i] & y2[i]) | (carry & (x2[i] ^ y2[i]));
      end else begin
        approx_c[i] = (x2[i] | y2[i]) ^ carry;
        carry       = (x2[i] | y2[i]) & carry;
      end
    end
  end

  assign exact_c = x2 + y2;
  assign err_c   = (approx_c != exact_c);

  // Valid bits and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      dat_o     <= '0;
      err_o     <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        dat_o <= approx_c;
        err_o <= err_c;
      end
    end
  end

  // Data payload of S1/S2; contents of invalid stages are don't-care
  always_ff @(posedge clk) begin
    if (en) begin
      a1 <= dat_in_a;
      b1 <= dat_in_b;
      m1 <= mask;
      x2 <= x_c;
      y2 <= y_c;
      m2 <= m1;
    end
  end

  // Error-event counter: clear beats increment, saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && err_o && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
